// File: rtl/npu8_host_pkg.sv
// Shared definitions for the NPU8 host-side command sequencer: command opcodes,
// sequencer states and the NPU8 CPU-port register map used by command lists.
package npu8_host_pkg;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_WAIT  = 2'd2,
    OP_NOP   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_INT_WAIT = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  // NPU8 CPU-port register map
  localparam logic [ADR_W-1:0] REG_CTRL     = 8'h00;
  localparam logic [ADR_W-1:0] REG_STATUS   = 8'h04;
  localparam logic [ADR_W-1:0] REG_IRQ_CLR  = 8'h08;
  localparam logic [ADR_W-1:0] REG_SRC_ADDR = 8'h10;
  localparam logic [ADR_W-1:0] REG_DST_ADDR = 8'h14;
  localparam logic [ADR_W-1:0] REG_LEN      = 8'h18;
  localparam logic [ADR_W-1:0] REG_CFG      = 8'h1C;

  // State entered when a command of the given opcode is accepted.
  function automatic state_e op_entry_state(cmd_op_e op);
    case (op)
      OP_WRITE: return S_WRITE;
      OP_READ:  return S_RD_ISSUE;
      OP_WAIT:  return S_INT_WAIT;
      default:  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/npu8_host_seq_if.sv
// Command/response handshake plus NPU8 CPU register bus seen by the sequencer.
// master = the sequencer; slave = the host feeding commands and the NPU port.
interface npu8_host_seq_if;
  import npu8_host_pkg::*;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [ADR_W-1:0]  CMD_ADR;
  logic [DATA_W-1:0] CMD_DATA;

  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_DATA;
  logic              RSP_ERR;

  logic [ADR_W-1:0]  ADR;
  logic              WR;
  logic              RD;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W-1:0] RDATA;
  logic              INT;
  logic              BUSY;

  modport master (
    input  CMD_VALID, CMD_OP, CMD_ADR, CMD_DATA, RSP_READY, RDATA, INT,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, ADR, WR, RD, WDATA, BUSY
  );

  modport slave (
    output CMD_VALID, CMD_OP, CMD_ADR, CMD_DATA, RSP_READY, RDATA, INT,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, ADR, WR, RD, WDATA, BUSY
  );

endinterface

// File: rtl/npu8_wait_timer.sv
// Saturating cycle counter with clear/enable and a "count reached limit-1" flag;
// a zero limit never hits.
module npu8_wait_timer #(
  parameter int TO_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic [TO_W-1:0] count,
  output logic            hit
);

  localparam logic [TO_W-1:0] ONE = TO_W'(1);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign hit   = (limit != '0) && (count_q == (limit - ONE));

endmodule

// File: rtl/npu8_host_seq.sv
// Host-side bus master for the NPU8 CPU port: turns WRITE/READ/WAIT_INT commands
// into single-cycle WR/RD strobes and returns read data or wait results.
module npu8_host_seq
  import npu8_host_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int TO_W   = 24
) (
  input logic            CLK,
  input logic            RESET,
  npu8_host_seq_if.master bus
);

  localparam logic [TO_W-1:0] RD_LAT_L = TO_W'(RD_LAT);

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [TO_W-1:0]   lim_q, lim_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  cmd_op_e           cmd_op;
  logic              cmd_ready;
  logic              cmd_fire;

  logic              tmr_clr;
  logic              tmr_en;
  logic [TO_W-1:0]   tmr_lim;
  logic [TO_W-1:0]   tmr_cnt;
  logic              tmr_hit;

  assign cmd_op    = cmd_op_e'(bus.CMD_OP);
  // Ready is decoded from state so it is low throughout reset and high right after.
  assign cmd_ready = (state_q == S_IDLE) && !RESET;
  assign cmd_fire  = bus.CMD_VALID && cmd_ready;

  // One counter serves both the read-latency delay and the interrupt wait.
  assign tmr_en  = (state_q == S_RD_WAIT) || (state_q == S_INT_WAIT);
  assign tmr_clr = !tmr_en;
  assign tmr_lim = (state_q == S_RD_WAIT) ? RD_LAT_L : lim_q;

  npu8_wait_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_lim),
    .count (tmr_cnt),
    .hit   (tmr_hit)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = '0;
    wdata_d    = '0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    lim_d      = lim_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d = op_entry_state(cmd_op);
          lim_d   = bus.CMD_DATA[TO_W-1:0];
          // Strobes are registered here so they appear in the cycle after acceptance.
          if (cmd_op == OP_WRITE) begin
            wr_d    = 1'b1;
            adr_d   = bus.CMD_ADR;
            wdata_d = bus.CMD_DATA;
          end else if (cmd_op == OP_READ) begin
            rd_d  = 1'b1;
            adr_d = bus.CMD_ADR;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (tmr_hit) begin
          rsp_data_d = bus.RDATA;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_INT_WAIT: begin
        // Interrupt wins over a timeout landing in the same cycle.
        if (bus.INT) begin
          rsp_data_d = DATA_W'(tmr_cnt);
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (tmr_hit) begin
          rsp_data_d = DATA_W'(lim_q);
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.RSP_READY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      lim_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      lim_q      <= lim_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.CMD_READY = cmd_ready;
  assign bus.RSP_VALID = (state_q == S_RESP);
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.ADR       = adr_q;
  assign bus.WR        = wr_q;
  assign bus.RD        = rd_q;
  assign bus.WDATA     = wdata_q;
  assign bus.BUSY      = (state_q != S_IDLE);

endmodule

// File: doc/npu8_host_seq.md
# npu8_host_seq

Bus-master command sequencer that drives the NPU8 CPU register interface (ADR/WR/RD/WDATA/RDATA/INT) from the host side. It accepts a stream of register commands (write, read, wait-for-interrupt), turns them into correctly timed bus pulses, and returns read data and wait results on a response handshake. It sits between a testbench or host processor model and the `npu8_top` CPU port, so that parameter programming, START, and completion polling run as command lists.

## Interface
Parameters:
- RD_LAT, 1, cycles from the RD pulse to valid RDATA; legal range 1..4.
- TO_W, 24, width of the wait counter and timeout limit.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_OP  in  2  0=WRITE, 1=READ, 2=WAIT_INT, 3=NOP.
- CMD_ADR  in  8  register address for WRITE/READ.
- CMD_DATA  in  32  write data (WRITE); timeout limit in [TO_W-1:0] (WAIT_INT, 0 = no timeout).
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed when VALID&READY.
- RSP_DATA  out  32  read data (READ) or waited cycle count, zero-extended (WAIT_INT).
- RSP_ERR  out  1  WAIT_INT timed out.
- ADR  out  8  bus address.
- WR  out  1  one-cycle write strobe.
- RD  out  1  one-cycle read strobe.
- WDATA  out  32  bus write data.
- RDATA  in  32  bus read data.
- INT  in  1  NPU interrupt, level-sensitive.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, INT_WAIT, RESP.
- IDLE: CMD_READY=1. On acceptance, latch OP/ADR/DATA and go to WRITE, RD_ISSUE, or INT_WAIT. NOP is accepted and stays in IDLE with no bus activity and no response.
- WRITE: WR=1, ADR and WDATA from the latched command for exactly one cycle, then IDLE. No response is generated.
- RD_ISSUE: RD=1 and ADR for one cycle, then RD_WAIT.
- RD_WAIT: count RD_LAT-1 cycles (zero cycles when RD_LAT=1). Sample RDATA at the edge RD_LAT cycles after the RD cycle, capture it into RSP_DATA with RSP_ERR=0, then RESP.
- INT_WAIT: a counter starts at 0 and increments each cycle, saturating at all-ones.
  - INT=1 in a cycle: RSP_DATA=count, RSP_ERR=0, go to RESP.
  - Else, if limit≠0 and count==limit-1: RSP_DATA=limit, RSP_ERR=1, go to RESP.
  - INT has priority over timeout in the same cycle.
  - An INT already high on entry completes with count 0.
- RESP: RSP_VALID=1 with RSP_DATA/RSP_ERR held stable until RSP_READY, then IDLE. CMD_READY=0 while in RESP.
- ADR and WDATA are driven to 0 whenever WR=0 and RD=0. WR and RD are never high together.

## Timing
- Reset values: CMD_READY=0 while RESET=1 and 1 from the first cycle after RESET falls. All other outputs are 0, state is IDLE, counters are 0.
- Reset mid-operation aborts the command in progress: any pending response is dropped, and no WR/RD appears in the cycle after RESET falls.
- Command accepted at edge T:
  - WR (or RD) is high during cycle T+1.
  - Next CMD_READY is in cycle T+2 for WRITE, so back-to-back writes run at 1 per 2 cycles.
- READ: RSP_VALID rises in the cycle after the RDATA sample. Minimum accept-to-RSP_VALID is RD_LAT+2 cycles.
- RSP_READY held high: the RESP state lasts 1 cycle.
- RSP_READY low: the response is held indefinitely with no bus activity.

## Structure
- Shared package `npu8_host_pkg`: CMD_OP encodings (OP_WRITE/OP_READ/OP_WAIT/OP_NOP), state enum, and the NPU8 register address constants used by command lists.
- One sub-module, `npu8_wait_timer`: TO_W-bit saturating counter with clear/enable and a limit-hit compare, used for both INT_WAIT and the RD_LAT delay.

## Test plan
- WRITE ADR=0x10, DATA=0xDEADBEEF → exactly one WR cycle with ADR=0x10 and WDATA=0xDEADBEEF; no response; CMD_READY returns 2 cycles after acceptance.
- READ ADR=0x04 with RD_LAT=1 and RDATA=0x0000_00A5 in the sample cycle → RSP_VALID with RSP_DATA=0xA5, RSP_ERR=0. Repeat with RD_LAT=3 and check the sample cycle.
- WAIT_INT, limit 100, INT rises 37 cycles after entry → RSP_DATA=37, RSP_ERR=0. Separately, INT already high on entry → RSP_DATA=0.
- WAIT_INT, limit 10, INT never asserts → RSP_DATA=10, RSP_ERR=1. Separately, INT rising exactly on the limit cycle → RSP_ERR=0.
- RSP_READY held low for 20 cycles after a READ → RSP_DATA stable, CMD_READY=0, no WR/RD.
- RESET asserted during RD_WAIT and during RESP → all outputs 0, no response or bus strobe afterwards. A following WRITE executes normally.
